// File: rtl/fc_pkg.sv
// Shared constants, score type and packer state encoding for the FC output path.
package fc_pkg;

    localparam int unsigned NUM_CLASSES = 2;
    localparam int unsigned ACC_W       = 32;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned FRAC_SHIFT  = 8;

    localparam int unsigned VALUES_W    = NUM_CLASSES * DATA_W;
    // One extra count so idx+1 == NUM_CLASSES is representable.
    localparam int unsigned IDX_W       = $clog2(NUM_CLASSES + 1);

    typedef logic signed [DATA_W-1:0] score_t;

    // 0x8000 marks an empty slot; data never maps onto it.
    localparam score_t SCORE_NONE = 16'h8000;
    localparam score_t SCORE_MAX  = 16'h7FFF;
    localparam score_t SCORE_MIN  = 16'h8001;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        PRESENT = 2'd3
    } packer_state_e;

endpackage

// File: rtl/fc_score_packer_if.sv
// Accumulator stream in, packed score frame out, plus status.
interface fc_score_packer_if
    import fc_pkg::*;
;
    logic                    acc_valid;
    logic                    acc_ready;
    logic signed [ACC_W-1:0] acc_data;
    logic                    acc_last;
    logic [VALUES_W-1:0]     values;
    logic                    values_valid;
    logic                    values_ready;
    logic                    frame_error;
    logic [7:0]              sat_count;

    // Environment side: drives beats, consumes frames.
    modport master (
        output acc_valid, acc_data, acc_last, values_ready,
        input  acc_ready, values, values_valid, frame_error, sat_count
    );

    // Packer side.
    modport slave (
        input  acc_valid, acc_data, acc_last, values_ready,
        output acc_ready, values, values_valid, frame_error, sat_count
    );

endinterface

// File: rtl/fc_score_saturate.sv
// Rescale a wide accumulator to a score, clamping symmetrically so 0x8000 is never produced.
module fc_score_saturate
    import fc_pkg::*;
(
    input  logic signed [ACC_W-1:0] acc_i,
    output score_t                  score_c_o,
    output logic                    sat_c_o
);

    localparam logic signed [ACC_W-1:0] POS_LIM = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] NEG_LIM = -POS_LIM;

    logic signed [ACC_W-1:0] shifted_c;

    // Arithmetic shift then clamp to [-32767, 32767].
    always_comb begin
        shifted_c = acc_i >>> FRAC_SHIFT;
        score_c_o = shifted_c[DATA_W-1:0];
        sat_c_o   = 1'b0;
        if (shifted_c > POS_LIM) begin
            score_c_o = SCORE_MAX;
            sat_c_o   = 1'b1;
        end else if (shifted_c < NEG_LIM) begin
            score_c_o = SCORE_MIN;
            sat_c_o   = 1'b1;
        end
    end

endmodule

// File: rtl/fc_score_packer.sv
// Packs the FC serial accumulator stream into one parallel score frame for Softmax.
module fc_score_packer
    import fc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    fc_score_packer_if.slave   bus
);

    packer_state_e       state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [VALUES_W-1:0] values_q, values_d;
    logic                acc_ready_q, acc_ready_d;
    logic                values_valid_q, values_valid_d;
    logic                frame_error_q, frame_error_d;
    logic [7:0]          sat_count_q, sat_count_d;

    score_t              score_c;
    logic                sat_c;
    logic                beat_c;
    logic                idx_full_c;

    fc_score_saturate u_sat (
        .acc_i     (bus.acc_data),
        .score_c_o (score_c),
        .sat_c_o   (sat_c)
    );

    assign beat_c     = bus.acc_valid && acc_ready_q;
    assign idx_full_c = (idx_q + IDX_W'(1)) == IDX_W'(NUM_CLASSES);

    // Next state, slot writes, error pulse and clamp counting.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        values_d      = values_q;
        frame_error_d = 1'b0;
        sat_count_d   = sat_count_q;

        case (state_q)
            IDLE, COLLECT: begin
                if (beat_c) begin
                    // Write this beat; on an early last, pad the rest with the empty marker.
                    for (int i = 0; i < int'(NUM_CLASSES); i++) begin
                        if (IDX_W'(i) == idx_q) begin
                            values_d[i*DATA_W +: DATA_W] = score_c;
                        end else if (bus.acc_last && (IDX_W'(i) > idx_q)) begin
                            values_d[i*DATA_W +: DATA_W] = SCORE_NONE;
                        end
                    end
                    if (sat_c && (sat_count_q != 8'hFF)) begin
                        sat_count_d = sat_count_q + 8'd1;
                    end
                    if (bus.acc_last) begin
                        state_d       = PRESENT;
                        idx_d         = '0;
                        frame_error_d = !idx_full_c;
                    end else if (idx_full_c) begin
                        state_d       = DRAIN;
                        idx_d         = '0;
                        frame_error_d = 1'b1;
                    end else begin
                        state_d = COLLECT;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                // Overlong frame: drop beats until last, keep what was collected.
                if (beat_c && bus.acc_last) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.values_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        acc_ready_d    = (state_d != PRESENT);
        values_valid_d = (state_d == PRESENT);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            values_q       <= {NUM_CLASSES{SCORE_NONE}};
            acc_ready_q    <= 1'b0;
            values_valid_q <= 1'b0;
            frame_error_q  <= 1'b0;
            sat_count_q    <= 8'd0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            values_q       <= values_d;
            acc_ready_q    <= acc_ready_d;
            values_valid_q <= values_valid_d;
            frame_error_q  <= frame_error_d;
            sat_count_q    <= sat_count_d;
        end
    end

    assign bus.acc_ready    = acc_ready_q;
    assign bus.values       = values_q;
    assign bus.values_valid = values_valid_q;
    assign bus.frame_error  = frame_error_q;
    assign bus.sat_count    = sat_count_q;

endmodule

// File: tb/tb_fc_score_packer.sv
// Directed bench for fc_score_packer: frame packing, clamping, short/long frames, stall, async reset.
module tb_fc_score_packer;
    import fc_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fc_score_packer_if bus ();

    fc_score_packer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one beat and wait until it transfers; called and returns at posedge+1.
    task automatic send_beat(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        bus.acc_valid = 1'b1;
        bus.acc_data  = d;
        bus.acc_last  = last;
        while (!bus.acc_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.acc_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: acc_ready=%0b after %0d cycles, required 1", bus.acc_ready, n);
        end
        @(posedge clk); #1;
        bus.acc_valid = 1'b0;
        bus.acc_last  = 1'b0;
    endtask

    // Hand the presented frame to the consumer.
    task automatic accept_frame();
        bus.values_ready = 1'b1;
        @(posedge clk); #1;
        bus.values_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.acc_ready !== 1'b0 || bus.values_valid !== 1'b0 || bus.frame_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%0b valid=%0b err=%0b, required 0 0 0",
                     bus.acc_ready, bus.values_valid, bus.frame_error);
        end
        checks++;
        if (bus.values !== 32'h8000_8000 || bus.sat_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: values=%h sat=%0d, required 80008000 0", bus.values, bus.sat_count);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.acc_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: acc_ready=%0b, required 1", bus.acc_ready);
        end
    endtask

    task automatic test_basic();
        send_beat(32'h0000_0300, 1'b0);
        send_beat(32'hFFFF_FE00, 1'b1);
        checks++;
        if (bus.values_valid !== 1'b1 || bus.values !== 32'hFFFE_0003 || bus.frame_error !== 1'b0) begin
            errors++;
            $display("FAIL basic_frame: valid=%0b values=%h err=%0b, required 1 fffe0003 0",
                     bus.values_valid, bus.values, bus.frame_error);
        end
        accept_frame();
    endtask

    task automatic test_saturation();
        send_beat(32'h7FFF_FFFF, 1'b0);
        send_beat(32'h8000_0000, 1'b1);
        checks++;
        if (bus.values !== 32'h8001_7FFF || bus.sat_count !== 8'd2) begin
            errors++;
            $display("FAIL sat_frame: values=%h sat=%0d, required 80017fff 2", bus.values, bus.sat_count);
        end
        checks++;
        if (bus.values[15:0] === 16'h8000 || bus.values[31:16] === 16'h8000) begin
            errors++;
            $display("FAIL sat_no_marker: values=%h, required no 8000 slot", bus.values);
        end
        accept_frame();
    endtask

    task automatic test_boundary();
        // 32767.5 truncates to max without clamping; -32768 clamps to 0x8001.
        send_beat(32'h007F_FF80, 1'b0);
        send_beat(32'hFF80_00FF, 1'b1);
        checks++;
        if (bus.values !== 32'h8001_7FFF || bus.sat_count !== 8'd3) begin
            errors++;
            $display("FAIL edge_frame_a: values=%h sat=%0d, required 80017fff 3", bus.values, bus.sat_count);
        end
        accept_frame();
        // -32767 passes through unclamped.
        send_beat(32'hFF80_0100, 1'b0);
        send_beat(32'h0000_8000, 1'b1);
        checks++;
        if (bus.values !== 32'h0080_8001 || bus.sat_count !== 8'd3) begin
            errors++;
            $display("FAIL edge_frame_b: values=%h sat=%0d, required 00808001 3", bus.values, bus.sat_count);
        end
        accept_frame();
    endtask

    task automatic test_short();
        send_beat(32'h0000_0100, 1'b1);
        checks++;
        if (bus.values_valid !== 1'b1 || bus.values !== 32'h8000_0001 || bus.frame_error !== 1'b1) begin
            errors++;
            $display("FAIL short_frame: valid=%0b values=%h err=%0b, required 1 80000001 1",
                     bus.values_valid, bus.values, bus.frame_error);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.frame_error !== 1'b0 || bus.values_valid !== 1'b1) begin
            errors++;
            $display("FAIL short_pulse: err=%0b valid=%0b, required 0 1", bus.frame_error, bus.values_valid);
        end
        accept_frame();
    endtask

    task automatic test_long();
        send_beat(32'h0000_0500, 1'b0);
        send_beat(32'h0000_0A00, 1'b0);
        checks++;
        if (bus.frame_error !== 1'b1 || bus.values_valid !== 1'b0) begin
            errors++;
            $display("FAIL long_err: err=%0b valid=%0b, required 1 0", bus.frame_error, bus.values_valid);
        end
        send_beat(32'h1234_5600, 1'b0);
        checks++;
        if (bus.frame_error !== 1'b0 || bus.values_valid !== 1'b0) begin
            errors++;
            $display("FAIL long_drain: err=%0b valid=%0b, required 0 0", bus.frame_error, bus.values_valid);
        end
        send_beat(32'h0000_0000, 1'b1);
        checks++;
        if (bus.values_valid !== 1'b1 || bus.values !== 32'h000A_0005 || bus.frame_error !== 1'b0) begin
            errors++;
            $display("FAIL long_frame: valid=%0b values=%h err=%0b, required 1 000a0005 0",
                     bus.values_valid, bus.values, bus.frame_error);
        end
        accept_frame();
    endtask

    task automatic test_back_to_back();
        int bad;
        send_beat(32'h0000_0100, 1'b0);
        send_beat(32'h0000_0200, 1'b1);
        // Next frame's first beat waits while the consumer stalls.
        bus.acc_valid = 1'b1;
        bus.acc_data  = 32'h0000_0700;
        bus.acc_last  = 1'b0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.acc_ready !== 1'b0 || bus.values_valid !== 1'b1 || bus.values !== 32'h0002_0001) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: %0d bad cycles, required 0 (ready=%0b valid=%0b values=%h)",
                     bad, bus.acc_ready, bus.values_valid, bus.values);
        end
        accept_frame();
        checks++;
        if (bus.acc_ready !== 1'b1 || bus.values_valid !== 1'b0 || bus.values !== 32'h0002_0001) begin
            errors++;
            $display("FAIL handoff: ready=%0b valid=%0b values=%h, required 1 0 00020001",
                     bus.acc_ready, bus.values_valid, bus.values);
        end
        @(posedge clk); #1;
        bus.acc_data = 32'h0000_0800;
        bus.acc_last = 1'b1;
        @(posedge clk); #1;
        bus.acc_valid = 1'b0;
        bus.acc_last  = 1'b0;
        checks++;
        if (bus.values_valid !== 1'b1 || bus.values !== 32'h0008_0007) begin
            errors++;
            $display("FAIL next_frame: valid=%0b values=%h, required 1 00080007", bus.values_valid, bus.values);
        end
        accept_frame();
    endtask

    task automatic test_async_reset();
        send_beat(32'h0000_0900, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.acc_ready !== 1'b0 || bus.values_valid !== 1'b0 || bus.frame_error !== 1'b0 ||
            bus.values !== 32'h8000_8000 || bus.sat_count !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: ready=%0b valid=%0b err=%0b values=%h sat=%0d, required 0 0 0 80008000 0",
                     bus.acc_ready, bus.values_valid, bus.frame_error, bus.values, bus.sat_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_beat(32'h0000_0A00, 1'b0);
        send_beat(32'h0000_0B00, 1'b1);
        checks++;
        if (bus.values_valid !== 1'b1 || bus.values !== 32'h000B_000A || bus.frame_error !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_frame: valid=%0b values=%h err=%0b, required 1 000b000a 0",
                     bus.values_valid, bus.values, bus.frame_error);
        end
        accept_frame();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b1;
        bus.acc_valid    = 1'b0;
        bus.acc_data     = '0;
        bus.acc_last     = 1'b0;
        bus.values_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_saturation();
        test_boundary();
        test_short();
        test_long();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
